// File: rtl/alu_sequencer_if.sv
// Request/response bundle for alu_sequencer: the master issues operations and consumes
// results, the slave (the sequencer) accepts operations and presents held responses.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_op1;
    logic [15:0] req_op2;
    logic [15:0] req_immd;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [15:0] rsp_r0;
    logic        flag_pos;
    logic        flag_neg;
    logic        div_by_zero;
    logic        illegal_op;
    logic        busy;

    modport master (
        output req_valid, req_op, req_op1, req_op2, req_immd, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_r0, flag_pos, flag_neg,
               div_by_zero, illegal_op, busy
    );

    modport slave (
        input  req_valid, req_op, req_op1, req_op2, req_immd, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_r0, flag_pos, flag_neg,
               div_by_zero, illegal_op, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Single-issue 16-bit ALU: one-cycle logic/add ops, 16-iteration shift-add multiply and
// restoring divide on magnitudes, with a held response and sticky sign flags.
module alu_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_ILL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_IMM = 3'b111;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_neg;
    logic        r_dneg;
    logic [16:0] r_a;
    logic [16:0] r_b;
    logic [15:0] r_rem;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic        r_rsp_valid;
    logic [15:0] r_result;
    logic [15:0] r_r0;
    logic        r_flag_pos;
    logic        r_flag_neg;
    logic        r_dbz;
    logic        r_ill;

    logic        w_accept;
    logic [16:0] w_mag1;
    logic [16:0] w_mag2;
    logic [15:0] w_fast_res;
    logic        w_fast_pos;
    logic        w_fast_neg;
    logic [31:0] w_acc_next;
    logic [31:0] w_prod;
    logic [16:0] w_rem_shift;
    logic        w_rem_ge;
    logic [15:0] w_rem_next;
    logic [15:0] w_quo_next;
    logic [15:0] w_quo_s;
    logic [15:0] w_rem_s;

    // 17 bits so that -32768 still has a representable magnitude
    function automatic logic [16:0] mag17(input logic [15:0] v);
        mag17 = v[15] ? (17'd0 - {1'b1, v}) : {1'b0, v};
    endfunction

    assign bus.req_ready   = (r_state == ST_IDLE) && !bus.flush;
    assign w_accept        = bus.req_valid && bus.req_ready;
    assign w_mag1          = mag17(bus.req_op1);
    assign w_mag2          = mag17(bus.req_op2);

    assign w_acc_next  = r_a[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod      = r_neg ? (32'd0 - w_acc_next) : w_acc_next;
    assign w_rem_shift = {r_rem, r_a[15]};
    assign w_rem_ge    = (w_rem_shift >= r_b);
    assign w_rem_next  = w_rem_ge ? 16'(w_rem_shift - r_b) : w_rem_shift[15:0];
    assign w_quo_next  = {r_a[14:0], w_rem_ge};
    assign w_quo_s     = r_neg ? (16'd0 - w_quo_next) : w_quo_next;
    assign w_rem_s     = r_dneg ? (16'd0 - w_rem_next) : w_rem_next;

    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_result  = r_result;
    assign bus.rsp_r0      = r_r0;
    assign bus.flag_pos    = r_flag_pos;
    assign bus.flag_neg    = r_flag_neg;
    assign bus.div_by_zero = r_dbz;
    assign bus.illegal_op  = r_ill;
    assign bus.busy        = (r_state != ST_IDLE);

    // Single-cycle result and flags; illegal ops leave the flags where they are
    always_comb begin
        w_fast_res = 16'd0;
        w_fast_pos = r_flag_pos;
        w_fast_neg = r_flag_neg;
        case (bus.req_op)
            OP_ADD: begin w_fast_res = bus.req_op1 + bus.req_op2;  w_fast_pos = 1'b0; w_fast_neg = 1'b0; end
            OP_SUB: begin
                w_fast_res = bus.req_op1 - bus.req_op2;
                w_fast_pos = !w_fast_res[15] && (w_fast_res != 16'd0);
                w_fast_neg = w_fast_res[15];
            end
            OP_AND: begin w_fast_res = bus.req_op1 & bus.req_op2;  w_fast_pos = 1'b0; w_fast_neg = 1'b0; end
            OP_OR:  begin w_fast_res = bus.req_op1 | bus.req_op2;  w_fast_pos = 1'b0; w_fast_neg = 1'b0; end
            OP_IMM: begin w_fast_res = bus.req_immd + bus.req_op2; w_fast_pos = 1'b0; w_fast_neg = 1'b0; end
            default: begin w_fast_res = 16'd0; w_fast_pos = r_flag_pos; w_fast_neg = r_flag_neg; end
        endcase
    end

    // Sequencer state, iteration datapath and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_neg       <= 1'b0;
            r_dneg      <= 1'b0;
            r_a         <= 17'd0;
            r_b         <= 17'd0;
            r_rem       <= 16'd0;
            r_acc       <= 32'd0;
            r_mcand     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_result    <= 16'd0;
            r_r0        <= 16'd0;
            r_flag_pos  <= 1'b0;
            r_flag_neg  <= 1'b0;
            r_dbz       <= 1'b0;
            r_ill       <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= 4'd0;
                        case (bus.req_op)
                            OP_MUL: begin
                                r_state <= ST_MUL;
                                r_neg   <= bus.req_op1[15] ^ bus.req_op2[15];
                                r_a     <= w_mag2;
                                r_mcand <= {15'd0, w_mag1};
                                r_acc   <= 32'd0;
                            end
                            OP_DIV: begin
                                if (bus.req_op2 == 16'd0) begin
                                    r_state     <= ST_DONE;
                                    r_rsp_valid <= 1'b1;
                                    r_result    <= 16'hFFFF;
                                    r_r0        <= bus.req_op1;
                                    r_dbz       <= 1'b1;
                                    r_ill       <= 1'b0;
                                    r_flag_pos  <= 1'b0;
                                    r_flag_neg  <= 1'b0;
                                end else begin
                                    r_state <= ST_DIV;
                                    r_neg   <= bus.req_op1[15] ^ bus.req_op2[15];
                                    r_dneg  <= bus.req_op1[15];
                                    r_a     <= w_mag1;
                                    r_b     <= w_mag2;
                                    r_rem   <= 16'd0;
                                end
                            end
                            default: begin
                                r_state     <= ST_DONE;
                                r_rsp_valid <= 1'b1;
                                r_result    <= w_fast_res;
                                r_r0        <= 16'd0;
                                r_dbz       <= 1'b0;
                                r_ill       <= (bus.req_op == OP_ILL);
                                r_flag_pos  <= w_fast_pos;
                                r_flag_neg  <= w_fast_neg;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> 1;
                    r_mcand <= r_mcand << 1;
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_result    <= w_prod[15:0];
                        r_r0        <= w_prod[31:16];
                        r_dbz       <= 1'b0;
                        r_ill       <= 1'b0;
                        r_flag_pos  <= 1'b0;
                        r_flag_neg  <= 1'b0;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_a   <= {1'b0, w_quo_next};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_result    <= w_quo_s;
                        r_r0        <= w_rem_s;
                        r_dbz       <= 1'b0;
                        r_ill       <= 1'b0;
                        r_flag_pos  <= 1'b0;
                        r_flag_neg  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer: expected responses come from a plain
// arithmetic model, are queued at accept time and checked by an independent monitor.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    alu_sequencer_if bus();

    alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [15:0] res;
        logic [15:0] r0;
        logic        dbz;
        logic        ill;
        logic        fpos;
        logic        fneg;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall = 0;
    bit   rand_rdy = 1'b0;
    bit   m_pos = 1'b0;
    bit   m_neg = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: arithmetic on plain ints, flags tracked as model state
    task automatic predict(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] imm, output exp_t e);
        int sa, sb, p, q, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.res = 16'd0; e.r0 = 16'd0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc_cyc = 0;
        case (op)
            3'b000: e.res = a + b;
            3'b001: e.res = a - b;
            3'b010: begin p = sa * sb; e.res = p[15:0]; e.r0 = p[31:16]; e.lat = 17; end
            3'b100: begin
                if (sb == 0) begin
                    e.res = 16'hFFFF; e.r0 = a; e.dbz = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    e.res = q[15:0]; e.r0 = r[15:0]; e.lat = 17;
                end
            end
            3'b101: e.res = a & b;
            3'b110: e.res = a | b;
            3'b111: e.res = imm + b;
            default: e.ill = 1'b1;
        endcase
        if (op == 3'b001) begin
            m_pos = ($signed(e.res) > 16'sd0);
            m_neg = ($signed(e.res) < 16'sd0);
        end else if (!e.ill) begin
            m_pos = 1'b0;
            m_neg = 1'b0;
        end
        e.fpos = m_pos;
        e.fneg = m_neg;
    endtask

    // Drives an op (entered just after a rising edge); returns one cycle after accept
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] imm, input bit push, output int acc_cyc);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = op;
        bus.req_op1 = a; bus.req_op2 = b; bus.req_immd = imm;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        acc_cyc = cyc;
        chk("accept_timeout", 32'(ok), 32'd1);
        if (ok && push) begin
            predict(op, a, b, imm, e);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op1 = 16'($urandom); bus.req_op2 = 16'($urandom); bus.req_immd = 16'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) begin ok = 1'b1; break; end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial forever begin
        @(posedge clk); #2;
        if (stall > 0) begin
            bus.rsp_ready = 1'b0;
            stall--;
        end else begin
            bus.rsp_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: latency at rise, stability while held, full compare at handshake
    initial begin : monitor
        exp_t        e;
        bit          prev_v;
        logic [15:0] h_res, h_r0;
        logic [3:0]  h_st;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (bus.rsp_valid && !prev_v) begin
                    if (exp_q.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                    else chk("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                    h_res = bus.rsp_result; h_r0 = bus.rsp_r0;
                    h_st  = {bus.div_by_zero, bus.illegal_op, bus.flag_pos, bus.flag_neg};
                end else if (bus.rsp_valid) begin
                    chk("hold_result", 32'(bus.rsp_result), 32'(h_res));
                    chk("hold_r0", 32'(bus.rsp_r0), 32'(h_r0));
                    chk("hold_status", 32'({bus.div_by_zero, bus.illegal_op, bus.flag_pos, bus.flag_neg}), 32'(h_st));
                end
                if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("result", 32'(bus.rsp_result), 32'(e.res));
                    chk("r0", 32'(bus.rsp_r0), 32'(e.r0));
                    chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                    chk("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
                    chk("flag_pos", 32'(bus.flag_pos), 32'(e.fpos));
                    chk("flag_neg", 32'(bus.flag_neg), 32'(e.fneg));
                end
                prev_v = bus.rsp_valid;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        chk({tag, "_rsp_r0"}, 32'(bus.rsp_r0), 32'd0);
        chk({tag, "_flags"}, 32'({bus.flag_pos, bus.flag_neg}), 32'd0);
        chk({tag, "_status"}, 32'({bus.div_by_zero, bus.illegal_op}), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_op1 = 16'd0; bus.req_op2 = 16'd0;
        bus.req_immd = 16'd0; bus.flush = 1'b0; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // Subtraction sign flags, then zero result clears both
        issue(3'b001, 16'd5, 16'd9, 16'd0, 1'b1, acc);
        wait_idle();
        issue(3'b001, 16'd7, 16'd7, 16'd0, 1'b1, acc);
        wait_idle();

        // Multiply latency and busy window
        issue(3'b010, 16'hFED4, 16'd200, 16'd0, 1'b1, acc);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("mul_busy", 32'(bus.busy), 32'd1);
            chk("mul_valid_window", 32'(bus.rsp_valid), 32'(k == 17));
        end
        @(negedge clk);
        chk("mul_idle_after", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;

        issue(3'b100, 16'hFFF9, 16'd2, 16'd0, 1'b1, acc);
        wait_idle();
        issue(3'b100, 16'd100, 16'd0, 16'd0, 1'b1, acc);
        wait_idle();
        issue(3'b010, 16'h8000, 16'h8000, 16'd0, 1'b1, acc);
        wait_idle();
        issue(3'b100, 16'h8000, 16'hFFFF, 16'd0, 1'b1, acc);
        wait_idle();
        issue(3'b011, 16'd1, 16'd2, 16'd0, 1'b1, acc);
        wait_idle();

        // Overflowing add held under back-pressure
        stall = 5;
        issue(3'b000, 16'h7FFF, 16'd1, 16'd0, 1'b1, acc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_result", 32'(bus.rsp_result), 32'h8000);
        end
        @(negedge clk);
        @(negedge clk);
        chk("stall_idle_busy", 32'(bus.busy), 32'd0);
        chk("stall_idle_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // Flush mid-multiply with a non-zero flag beforehand
        issue(3'b001, 16'd1, 16'd4, 16'd0, 1'b1, acc);
        wait_idle();
        issue(3'b010, 16'd1234, 16'd77, 16'd0, 1'b0, acc);
        repeat (7) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("flush_no_valid", 32'(bus.rsp_valid), 32'd0);
            if (k == 0) begin
                chk("flush_busy", 32'(bus.busy), 32'd0);
                chk("flush_flags", 32'({bus.flag_pos, bus.flag_neg}), 32'({m_pos, m_neg}));
            end
        end
        @(posedge clk); #1;
        issue(3'b000, 16'd2, 16'd3, 16'd0, 1'b1, acc);
        wait_idle();

        // Reset in the middle of a divide
        issue(3'b001, 16'd1, 16'd2, 16'd0, 1'b1, acc);
        wait_idle();
        issue(3'b100, 16'd1000, 16'd7, 16'd0, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        m_pos = 1'b0;
        m_neg = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom_range(0, 7)), rnd16(), rnd16(), rnd16(), 1'b1, acc);
        end
        wait_idle();
        rand_rdy = 1'b0;
        wait_idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  block accepts an operation this cycle; transfer when req_valid && req_ready.
REQ-006 req_op  input  3  000 ADD, 001 SUB, 010 MUL, 100 DIV, 101 AND, 110 OR, 111 IMMADD, 011 illegal.
REQ-007 req_op1, req_op2  input  16  signed operands.
REQ-008 req_immd  input  16  unsigned immediate, used by IMMADD only.
REQ-009 flush  input  1  synchronous abort of any in-flight operation.
REQ-010 rsp_valid  output  1  response held valid.
REQ-011 rsp_ready  input  1  consumer takes response; transfer when rsp_valid && rsp_ready.
REQ-012 rsp_result  output  16  low result word or quotient.
REQ-013 rsp_r0  output  16  high product word or remainder; 0 for other ops.
REQ-014 flag_pos, flag_neg  output  1 each  registered sign flags.
REQ-015 div_by_zero, illegal_op  output  1 each  status, valid with rsp_valid.
REQ-016 busy  output  1  high in MUL, DIV or DONE state.

Function
REQ-017 The FSM SHALL have states IDLE, MUL, DIV, DONE; req_ready = (state == IDLE) && !flush.
REQ-018 Accept in IDLE of ADD/SUB/AND/OR/IMMADD/illegal SHALL compute the result in the accept cycle and enter DONE; rsp_valid rises at accept+1.
REQ-019 ADD, SUB, IMMADD (req_immd + req_op2) SHALL wrap modulo 2^16; AND/OR bitwise.
REQ-020 Accept of MUL SHALL enter MUL; accept of DIV with req_op2 != 0 SHALL enter DIV; a 4-bit counter SHALL run 16 iterations, one bit per cycle, then enter DONE; rsp_valid rises at accept+17.
REQ-021 MUL SHALL operate on 17-bit magnitudes (shift-add), apply sign = sign(op1) XOR sign(op2), and return the full signed 32-bit product as {rsp_r0, rsp_result}; -32768 * -32768 = 32'h4000_0000.
REQ-022 DIV SHALL use restoring division on magnitudes, truncate toward zero, remainder sign = dividend sign; -32768 / -1 SHALL return result 16'h8000, r0 0.
REQ-023 DIV with req_op2 == 0 SHALL skip DIV state, enter DONE at accept+1 with rsp_result 16'hFFFF, rsp_r0 = req_op1, div_by_zero 1.
REQ-024 Op 011 SHALL produce rsp_result 0, rsp_r0 0, illegal_op 1, flags unchanged.
REQ-025 On response completion, SUB SHALL set flag_pos = (result > 0), flag_neg = (result < 0), both 0 on zero result; all other legal ops SHALL clear both flags.
REQ-026 Flags SHALL update in the cycle rsp_valid rises and hold until the next completion.
REQ-027 In DONE, rsp_* outputs SHALL be stable while rsp_valid && !rsp_ready; on rsp_ready the FSM SHALL return to IDLE next cycle (min two cycles per op).
REQ-028 Operands SHALL be captured at accept; input changes afterward SHALL not affect the result.
REQ-029 flush SHALL force IDLE next cycle from any state, drop any response (rsp_valid 0), leave flags unchanged; flush has priority over accept and rsp_ready.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 Asynchronous reset SHALL force state IDLE, counter 0, rsp_valid 0, rsp_result 0, rsp_r0 0, flag_pos 0, flag_neg 0, div_by_zero 0, illegal_op 0, busy 0; req_ready 1 after reset release.
REQ-032 Reset asserted mid-MUL/DIV SHALL discard the operation with no response after release.

Verification
REQ-033 SUB 5 - 9, rsp_ready 1 -> rsp_valid at accept+1, rsp_result 16'hFFFC, flag_neg 1, flag_pos 0; then SUB 7 - 7 -> result 0, both flags 0.
REQ-034 MUL -300 * 200 -> rsp_valid at accept+17, {rsp_r0, rsp_result} = 32'hFFFF_15A0, busy high accept+1..accept+17.
REQ-035 DIV -7 / 2 -> result 16'hFFFD (-3), r0 16'hFFFF (-1); DIV 100 / 0 -> accept+1, result 16'hFFFF, r0 100, div_by_zero 1.
REQ-036 ADD 16'h7FFF + 1 with rsp_ready low for 5 cycles -> result 16'h8000 held stable, req_ready 0 throughout, IDLE one cycle after rsp_ready.
REQ-037 flush at accept+8 of MUL -> IDLE next cycle, no rsp_valid, flags unchanged; new ADD 2 + 3 then returns 5.
REQ-038 rst_n low at accept+5 of DIV -> all outputs at reset values, no response after release.
